warp_issue_sched: RTL and testbench
===================================

Name: warp_issue_sched

Overview:
- Issue scheduler in front of the instruction demux.
- Selects one ready instruction per cycle from NUM_WARPS per-warp instruction-buffer heads, round-robin.
- Skips warps whose target execute unit reports not-ready, which avoids head-of-line blocking.
- Presents the winner through a single registered valid/ready stage, the issue port the demux consumes.

Parameters:
- NUM_WARPS, 4, number of requesting warps (≥2; need not be a power of two).
- NW_BITS, $clog2(NUM_WARPS), warp id width.
- EX_BITS, 3, execute-type encoding width.
- DATAW, 64, opaque per-instruction payload width (PC, op_type, op_mod, rd, wb, imm, ...).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- warp_valid  in  NUM_WARPS  per-warp head instruction valid.
- warp_ex_type  in  NUM_WARPS*EX_BITS  per-warp target unit (NOP=0, ALU=1, LSU=2, CSR=3, FPU=4, GPU=5).
- warp_data  in  NUM_WARPS*DATAW  per-warp payload.
- warp_ready  out  NUM_WARPS  one-hot pop strobe to the granted warp's buffer.
- unit_ready  in  2**EX_BITS  per-ex_type acceptance hint from the demux; bit 0 ignored.
- out_valid  out  1  issue valid.
- out_wid  out  NW_BITS  issued warp id.
- out_ex_type  out  EX_BITS  issued ex_type.
- out_data  out  DATAW  issued payload.
- out_ready  in  1  demux accepts.
- perf_stall_cycles  out  32  saturating count of cycles with pending work but no grant.

Behaviour:
- Reset (async assert, sync deassert internally not required):
  - out_valid=0, out_wid=0, out_ex_type=0, out_data=0.
  - rr_ptr=0, perf_stall_cycles=0.
  - warp_ready is combinational and 0 while reset is asserted.
- Eligibility: elig[w] = warp_valid[w] && (ex_type[w]==NOP || unit_ready[ex_type[w]]).
  - ex_type values 6,7 are eligible and treated like NOP.
- Load condition: load = !out_valid || out_ready.
- Pick, when load && |elig:
  - grant = first w with elig[w], searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, …, NUM_WARPS-1, 0, …).
  - warp_ready[grant]=1 in the same cycle; all other bits are 0.
  - At the clock edge: out_valid<=1, out_wid<=grant, out_ex_type/out_data<=that warp's fields.
  - rr_ptr<=grant+1, wrapping from NUM_WARPS-1 to 0.
- No pick:
  - load && !|elig: out_valid<=0, rr_ptr unchanged, payload registers may hold.
  - !load: warp_ready=0 and all output registers hold. Hold is stable and depends on out_ready only. A later drop of unit_ready does not revoke an issued instruction.
- Latency and throughput:
  - Grant to out_valid is 1 cycle.
  - Back-to-back issue at 1/cycle when out_ready stays high (drain and refill in the same cycle).
- Fairness:
  - A continuously eligible warp is granted within NUM_WARPS grants.
  - A warp that becomes ineligible loses no priority position.
- perf_stall_cycles:
  - Increments by 1 on any cycle where |warp_valid && !(load && |elig).
  - Saturates at 32'hFFFF_FFFF.
- warp_ready is a pure function of the current-cycle inputs and state. Upstream must hold warp_valid/ex_type/data stable until popped.
- Reset asserted mid-transfer: the pending out entry is discarded and is not re-issued. The upstream buffers are reset by the same reset.

Decomposition:
- Shared package (issue_pkg):
  - EX_* ex_type localparams and EX_BITS.
  - Shared with the demux and decode.
- Sub-module issue_rr_pick:
  - Combinational rotate-priority picker.
  - Inputs: req[NUM_WARPS], ptr.
  - Outputs: grant one-hot, grant_idx, any.
  - Implemented by double-width masked priority, no loops over runtime indices.
- Top holds rr_ptr, the output register stage, the perf counter and the payload mux.

Test Plan:
- Reset then all four warps valid, ex_type=ALU, unit_ready=all-1, out_ready=1:
  - Issue order is wid 0,1,2,3,0 on consecutive cycles.
  - out_valid rises 1 cycle after the first grant.
  - perf_stall_cycles stays 0.
- Warp0=LSU, warp1=ALU, unit_ready[LSU]=0, rr_ptr=0:
  - wid1 is granted.
  - warp_ready=4'b0010.
  - Warp0 is untouched.
  - perf_stall_cycles unchanged.
- out_ready=0 for 3 cycles while out_valid=1, other warps valid:
  - warp_ready=0 throughout, outputs hold.
  - perf_stall_cycles +3.
  - On out_ready=1, the next grant occurs in that same cycle.
- NUM_WARPS=3, all valid, rr_ptr reaches 2:
  - Next grant order is 2 then 0, confirming wrap without reaching an index of 3.
- Preload perf_stall_cycles near saturation via forced stall (or a small-width test build), all warps stalled:
  - Count stops at all-ones and does not wrap.
- Assert reset (low) while out_valid=1 mid-stream:
  - out_valid=0 and out_data=0 asynchronously.
  - After release, the first grant starts from wid0.

Source files
------------

// File: rtl/issue_pkg.sv
// Execute-unit encodings shared by the issue scheduler, the demux and decode.
package issue_pkg;

  localparam int EX_BITS = 3;

  localparam logic [EX_BITS-1:0] EX_NOP = 3'd0;
  localparam logic [EX_BITS-1:0] EX_ALU = 3'd1;
  localparam logic [EX_BITS-1:0] EX_LSU = 3'd2;
  localparam logic [EX_BITS-1:0] EX_CSR = 3'd3;
  localparam logic [EX_BITS-1:0] EX_FPU = 3'd4;
  localparam logic [EX_BITS-1:0] EX_GPU = 3'd5;

  // Codes outside ALU..GPU (NOP and the unused 6/7) need no execute unit.
  function automatic logic ex_needs_unit(input logic [EX_BITS-1:0] ex);
    return (ex >= EX_ALU) && (ex <= EX_GPU);
  endfunction

endpackage

// File: rtl/issue_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr_i, wrapping around.
module issue_rr_pick #(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] req_i,
  input  logic [NW_BITS-1:0]   ptr_i,
  output logic [NUM_WARPS-1:0] grant_o,
  output logic [NW_BITS-1:0]   grant_idx_o,
  output logic                 any_o
);

  logic [2*NUM_WARPS-1:0] req2;
  logic [2*NUM_WARPS-1:0] masked;
  logic [2*NUM_WARPS-1:0] iso;

  // The upper copy catches requests below ptr_i once the lower copy is masked off.
  assign req2    = {req_i, req_i};
  assign masked  = req2 & ({(2*NUM_WARPS){1'b1}} << ptr_i);
  assign iso     = masked & (~masked + (2*NUM_WARPS)'(1));
  assign grant_o = iso[NUM_WARPS-1:0] | iso[2*NUM_WARPS-1:NUM_WARPS];
  assign any_o   = |req_i;

  always_comb begin
    grant_idx_o = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (grant_o[i]) grant_idx_o = grant_idx_o | NW_BITS'(i);
    end
  end

endmodule

// File: rtl/warp_issue_sched.sv
// Round-robin issue scheduler: picks one eligible warp head per cycle into a
// single registered issue stage feeding the instruction demux.
module warp_issue_sched
  import issue_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = $clog2(NUM_WARPS),
  parameter int DATAW     = 64
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [NUM_WARPS-1:0]         warp_valid_i,
  input  logic [NUM_WARPS*EX_BITS-1:0] warp_ex_type_i,
  input  logic [NUM_WARPS*DATAW-1:0]   warp_data_i,
  output logic [NUM_WARPS-1:0]         warp_ready_o,
  input  logic [2**EX_BITS-1:0]        unit_ready_i,
  output logic                         out_valid_o,
  output logic [NW_BITS-1:0]           out_wid_o,
  output logic [EX_BITS-1:0]           out_ex_type_o,
  output logic [DATAW-1:0]             out_data_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  perf_stall_cycles_o
);

  // Handshake: a transfer happens on a clock edge where valid and ready are both
  // high. warp_valid/ex_type/data hold until warp_ready pops them; out_* hold
  // while out_valid is high and out_ready is low.

  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] grant;
  logic [NW_BITS-1:0]   grant_idx;
  logic                 any_elig;
  logic                 load;
  logic                 pick;
  logic                 stall;
  logic [EX_BITS-1:0]   ex_w;
  logic [EX_BITS-1:0]   sel_ex;
  logic [DATAW-1:0]     sel_data;

  logic                 out_valid_q, out_valid_d;
  logic [NW_BITS-1:0]   out_wid_q, out_wid_d;
  logic [EX_BITS-1:0]   out_ex_q, out_ex_d;
  logic [DATAW-1:0]     out_data_q, out_data_d;
  logic [NW_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]          perf_q, perf_d;

  always_comb begin
    ex_w = '0;
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      ex_w    = warp_ex_type_i[w*EX_BITS +: EX_BITS];
      elig[w] = warp_valid_i[w] && (!ex_needs_unit(ex_w) || unit_ready_i[ex_w]);
    end
  end

  issue_rr_pick #(
    .NUM_WARPS (NUM_WARPS),
    .NW_BITS   (NW_BITS)
  ) u_pick (
    .req_i       (elig),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_elig)
  );

  always_comb begin
    sel_ex   = '0;
    sel_data = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (grant_idx == NW_BITS'(w)) begin
        sel_ex   = warp_ex_type_i[w*EX_BITS +: EX_BITS];
        sel_data = warp_data_i[w*DATAW +: DATAW];
      end
    end
  end

  assign load         = !out_valid_q || out_ready_i;
  assign pick         = load && any_elig;
  assign stall        = (|warp_valid_i) && !pick;
  assign warp_ready_o = (reset_ni && pick) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_wid_d   = out_wid_q;
    out_ex_d    = out_ex_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = any_elig;
      if (any_elig) begin
        out_wid_d  = grant_idx;
        out_ex_d   = sel_ex;
        out_data_d = sel_data;
        rr_ptr_d   = (grant_idx == NW_BITS'(NUM_WARPS-1)) ? '0 : grant_idx + NW_BITS'(1);
      end
    end
    perf_d = (stall && !(&perf_q)) ? perf_q + 32'd1 : perf_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_ex_q    <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      perf_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_wid_q   <= out_wid_d;
      out_ex_q    <= out_ex_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      perf_q      <= perf_d;
    end
  end

  assign out_valid_o         = out_valid_q;
  assign out_wid_o           = out_wid_q;
  assign out_ex_type_o       = out_ex_q;
  assign out_data_o          = out_data_q;
  assign perf_stall_cycles_o = perf_q;

endmodule

// File: tb/tb_warp_issue_sched.sv
// Bench for warp_issue_sched: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the issue rules.
module tb_warp_issue_sched;

  localparam int N   = 4;
  localparam int EXB = 3;
  localparam int DW  = 64;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    warp_valid = '0;
  logic [N*EXB-1:0] warp_ex_type = '0;
  logic [N*DW-1:0] warp_data = '0;
  logic [N-1:0]    warp_ready;
  logic [7:0]      unit_ready = '0;
  logic            out_valid;
  logic [1:0]      out_wid;
  logic [EXB-1:0]  out_ex_type;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b0;
  logic [31:0]     perf;

  // Second instance with a non-power-of-two warp count.
  logic [2:0]      w3_valid = 3'b111;
  logic [3*EXB-1:0] w3_ex = {3'd1, 3'd1, 3'd1};
  logic [3*DW-1:0] w3_data = '0;
  logic [2:0]      w3_ready;
  logic            w3_out_valid;
  logic [1:0]      w3_out_wid;
  logic [EXB-1:0]  w3_out_ex;
  logic [DW-1:0]   w3_out_data;
  logic [31:0]     w3_perf;

  always #5 clk = ~clk;

  warp_issue_sched #(.NUM_WARPS(N), .DATAW(DW)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .warp_valid_i(warp_valid), .warp_ex_type_i(warp_ex_type), .warp_data_i(warp_data),
    .warp_ready_o(warp_ready), .unit_ready_i(unit_ready),
    .out_valid_o(out_valid), .out_wid_o(out_wid), .out_ex_type_o(out_ex_type),
    .out_data_o(out_data), .out_ready_i(out_ready), .perf_stall_cycles_o(perf)
  );

  warp_issue_sched #(.NUM_WARPS(3), .DATAW(DW)) dut3 (
    .clk_i(clk), .reset_ni(reset_n),
    .warp_valid_i(w3_valid), .warp_ex_type_i(w3_ex), .warp_data_i(w3_data),
    .warp_ready_o(w3_ready), .unit_ready_i(8'hFF),
    .out_valid_o(w3_out_valid), .out_wid_o(w3_out_wid), .out_ex_type_o(w3_out_ex),
    .out_data_o(w3_out_data), .out_ready_i(1'b1), .perf_stall_cycles_o(w3_perf)
  );

  // Upstream buffer heads and the reference model state.
  bit          h_valid[N];
  logic [2:0]  h_ex[N];
  logic [63:0] h_data[N];
  bit          m_valid;
  int          m_wid;
  logic [2:0]  m_ex;
  logic [63:0] m_data;
  int          m_ptr;
  logic [31:0] m_perf;
  logic [63:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit eligible(input int w);
    return h_valid[w] && (h_ex[w] == 0 || h_ex[w] > 5 || unit_ready[h_ex[w]]);
  endfunction

  task automatic new_head(input int w);
    h_valid[w] = 1'b1;
    h_ex[w]    = 3'($urandom_range(0, 7));
    h_data[w]  = {$urandom, $urandom};
  endtask

  task automatic set_all(input logic [2:0] ex);
    for (int w = 0; w < N; w++) begin
      h_valid[w] = 1'b1;
      h_ex[w]    = ex;
      h_data[w]  = {$urandom, $urandom};
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < N; w++) begin
      h_valid[w] = 1'b0;
      h_ex[w]    = '0;
      h_data[w]  = '0;
    end
    m_valid = 1'b0; m_wid = 0; m_ex = '0; m_data = '0; m_ptr = 0; m_perf = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_wid", out_wid, 0);
    check("rst_ex", out_ex_type, 0);
    check("rst_data", out_data, 0);
    check("rst_perf", perf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle; entered and left in the low phase of the clock.
  // refill: 0 popped head empties, 1 random next head, 2 same ex new data.
  task automatic step(input int refill);
    int g;
    bit ld;
    bit any_valid;
    logic [N-1:0] exp_wr;
    for (int w = 0; w < N; w++) begin
      warp_valid[w]             = h_valid[w];
      warp_ex_type[w*EXB +: EXB] = h_ex[w];
      warp_data[w*DW +: DW]     = h_data[w];
    end
    #1;
    ld = !m_valid || out_ready;
    g  = -1;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && eligible((m_ptr + k) % N)) g = (m_ptr + k) % N;
      if (h_valid[k]) any_valid = 1'b1;
    end
    exp_wr = '0;
    if (ld && g >= 0) exp_wr[g] = 1'b1;
    check("warp_ready", warp_ready, exp_wr);
    if (m_valid && out_ready) begin
      if (exp_q.size() > 0) check("issued_data", out_data, exp_q.pop_front());
      else check("sb_empty", 0, 1);
    end
    @(posedge clk);
    #1;
    if (any_valid && !(ld && g >= 0) && m_perf != 32'hFFFF_FFFF) m_perf++;
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_wid = g; m_ex = h_ex[g]; m_data = h_data[g];
        exp_q.push_back(h_data[g]);
        m_ptr = (g + 1) % N;
        case (refill)
          0: h_valid[g] = 1'b0;
          1: if ($urandom_range(0, 1) == 1) new_head(g); else h_valid[g] = 1'b0;
          default: h_data[g] = {$urandom, $urandom};
        endcase
      end else begin
        m_valid = 1'b0;
      end
    end
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_wid", out_wid, m_wid);
      check("out_ex", out_ex_type, m_ex);
      check("out_data", out_data, m_data);
    end
    check("perf", perf, m_perf);
    @(negedge clk);
  endtask

  int seq4[5] = '{0, 1, 2, 3, 0};
  int seq3[5] = '{0, 1, 2, 0, 1};
  logic [31:0] perf_before;

  initial begin
    model_reset();
    do_reset();

    // All ALU, always ready: strict rotation on both instances.
    set_all(3'd1);
    unit_ready = 8'hFF;
    out_ready  = 1'b1;
    check("valid_before_grant", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step(2);
      check("rr_order", out_wid, seq4[i]);
      check("rr3_order", w3_out_wid, seq3[i]);
    end
    check("no_stall", perf, 0);

    // LSU blocked: warp1 is granted past warp0.
    do_reset();
    h_valid[0] = 1'b1; h_ex[0] = 3'd2; h_data[0] = 64'hAAAA_0000_0000_0000;
    h_valid[1] = 1'b1; h_ex[1] = 3'd1; h_data[1] = 64'h1111_2222_3333_4444;
    unit_ready = 8'hFB;
    out_ready  = 1'b1;
    step(0);
    check("skip_wid", out_wid, 1);
    check("skip_perf", perf, 0);
    step(0);

    // Backpressure hold for three cycles, then refill in the accepting cycle.
    set_all(3'd1);
    unit_ready = 8'hFF;
    step(2);
    out_ready   = 1'b0;
    perf_before = perf;
    repeat (3) step(2);
    check("hold_perf", perf, perf_before + 32'd3);
    out_ready = 1'b1;
    step(2);

    // Asynchronous reset while an entry is pending.
    check("pending_before_reset", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_wready", warp_ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    set_all(3'd5);
    step(2);
    check("after_rst_wid", out_wid, 0);

    // Stall counter saturation from a preloaded value.
    set_all(3'd2);
    unit_ready = 8'hFB;
    force dut.perf_q = 32'hFFFF_FFFD;
    #1 release dut.perf_q;
    m_perf = 32'hFFFF_FFFD;
    repeat (4) step(2);
    check("perf_saturated", perf, 32'hFFFF_FFFF);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int w = 0; w < N; w++) begin
        if (!h_valid[w] && $urandom_range(0, 1) == 1) new_head(w);
      end
      unit_ready = 8'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
